// File: rtl/cpuv2_bus_pkg.sv
// Shared bus definitions for the two-master memory bus arbiter.
package cpuv2_bus_pkg;

    localparam int BUS_AW   = 32;
    localparam int BUS_DW   = 32;
    localparam int BUS_SELW = 4;

    localparam logic [BUS_DW-1:0] TMO_DEAD_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_arb_timer.sv
// Watchdog counter for a granted transfer; used only when ARB_TIMEOUT_EN is defined.
module bus_arb_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the cpu (m0) and DMA/loader (m1).
// Define ARB_TIMEOUT_EN to terminate transfers the slave never acknowledges.
module bus_arbiter
    import cpuv2_bus_pkg::*;
#(
    parameter int AW      = BUS_AW,
    parameter int DW      = BUS_DW,
    parameter int TMO_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_ni,
    input  logic [AW-1:0]       m0_adr_i,
    input  logic [DW-1:0]       m0_dat_i,
    input  logic                m0_we_i,
    input  logic [BUS_SELW-1:0] m0_sel_i,
    input  logic                m0_stb_i,
    output logic [DW-1:0]       m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    input  logic [AW-1:0]       m1_adr_i,
    input  logic [DW-1:0]       m1_dat_i,
    input  logic                m1_we_i,
    input  logic [BUS_SELW-1:0] m1_sel_i,
    input  logic                m1_stb_i,
    output logic [DW-1:0]       m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [DW-1:0]       s_dat_o,
    output logic                s_we_o,
    output logic [BUS_SELW-1:0] s_sel_o,
    output logic                s_stb_o,
    input  logic [DW-1:0]       s_dat_i,
    input  logic                s_ack_i,
    output logic [1:0]          gnt_o
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;   // 0: m0 was served last, 1: m1
    logic       tmo_hit;

`ifdef ARB_TIMEOUT_EN
    logic gstb;
    logic tmr_expire;

    assign gstb = ((state_q == GNT0) && m0_stb_i) || ((state_q == GNT1) && m1_stb_i);

    bus_arb_timer #(.LIMIT(TMO_CYC)) u_timer (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .clr_i   (state_q == IDLE),
        .en_i    (gstb && !s_ack_i),
        .expire_o(tmr_expire)
    );

    // A genuine ack in the expiry cycle wins and reports no error.
    assign tmo_hit = tmr_expire && gstb && !s_ack_i;
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_stb_i && (!m1_stb_i || last_q)) state_d = GNT0;
                else if (m1_stb_i)                     state_d = GNT1;
            end
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_stb_o  = m0_stb_i && !tmo_hit;
                m0_ack_o = (s_ack_i && m0_stb_i) || tmo_hit;
                m0_err_o = tmo_hit;
                m0_dat_o = tmo_hit ? DW'(TMO_DEAD_DATA) : s_dat_i;
                // An abort releases the bus without counting as a served turn.
                if (!m0_stb_i) begin
                    state_d = IDLE;
                end else if (s_ack_i || tmo_hit) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_stb_o  = m1_stb_i && !tmo_hit;
                m1_ack_o = (s_ack_i && m1_stb_i) || tmo_hit;
                m1_err_o = tmo_hit;
                m1_dat_o = tmo_hit ? DW'(TMO_DEAD_DATA) : s_dat_i;
                if (!m1_stb_i) begin
                    state_d = IDLE;
                end else if (s_ack_i || tmo_hit) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign gnt_o = {state_q == GNT1, state_q == GNT0};

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: two master drivers, a slave model with
// random ack latency and stray acks, and a negedge monitor checking grants and data.
module tb_bus_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m1_adr_i = '0, m1_dat_i = '0;
    logic        m0_we_i = 1'b0, m0_stb_i = 1'b0, m1_we_i = 1'b0, m1_stb_i = 1'b0;
    logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o, s_stb_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i = '0;
    logic        s_ack_i = 1'b0;
    logic [1:0]  gnt_o;

    bus_arbiter #(.AW(32), .DW(32), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
    } req_t;

    req_t exp0_q[$], exp1_q[$];
    int   checks = 0, errors = 0;
    bit   stop = 1'b0, mon_en = 1'b0, slave_mute = 1'b0;
    bit   ack_seen[2];
    int   last_srv = 1;   // reference: which master completed most recently
    logic [1:0] prev_g = '0;
    logic prev_s0 = 1'b0, prev_s1 = 1'b0, prev_a0 = 1'b0, prev_a1 = 1'b0;
    int   served0 = 0, served1 = 0;

    function automatic logic [31:0] rdata(input logic [31:0] a);
        return 32'h1000_0000 | (a >> 3);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Slave: acks after 0..3 stb cycles with address-derived read data; stray acks when idle.
    initial begin
        int scnt, sdly;
        scnt = 0;
        sdly = $urandom_range(0, 3);
        forever begin
            @(posedge clk);
            #2;
            if (!rst_ni || slave_mute) begin
                s_ack_i = 1'b0;
                scnt    = 0;
            end else if (s_stb_o) begin
                if (scnt >= sdly) begin
                    s_ack_i = 1'b1;
                    s_dat_i = rdata(s_adr_o);
                    scnt    = 0;
                    sdly    = $urandom_range(0, 3);
                end else begin
                    s_ack_i = 1'b0;
                    scnt++;
                end
            end else begin
                scnt    = 0;
                s_ack_i = ($urandom_range(0, 7) == 0);
                s_dat_i = $urandom;
            end
        end
    end

    task automatic set_m(input int m, input req_t r, input logic stb);
        if (m == 0) begin
            m0_adr_i = r.adr; m0_dat_i = r.dat; m0_we_i = r.we; m0_sel_i = r.sel; m0_stb_i = stb;
        end else begin
            m1_adr_i = r.adr; m1_dat_i = r.dat; m1_we_i = r.we; m1_sel_i = r.sel; m1_stb_i = stb;
        end
    endtask

    task automatic master_run(input int m);
        req_t r;
        int   n, lim;
        bit   abort;
        while (!stop) begin
            @(posedge clk);
            #1;
            if (stop) break;
            if ($urandom_range(0, 2) != 0) continue;
            r.adr = $urandom & 32'hFFFF_FFFC;
            r.dat = $urandom;
            r.we  = 1'($urandom_range(0, 1));
            r.sel = 4'($urandom_range(1, 15));
            if (m == 0) exp0_q.push_back(r); else exp1_q.push_back(r);
            set_m(m, r, 1'b1);
            abort = ($urandom_range(0, 5) == 0);
            lim   = $urandom_range(1, 3);
            n     = 0;
            forever begin
                @(posedge clk);
                #1;
                if (ack_seen[m]) begin
                    set_m(m, r, 1'b0);
                    break;
                end
                n++;
                if ((abort && n >= lim) || n > 200) begin
                    if (n > 200) chk($sformatf("m%0d_wait_bound", m), 64'(n), 64'd0);
                    set_m(m, r, 1'b0);
                    if (m == 0) void'(exp0_q.pop_front()); else void'(exp1_q.pop_front());
                    break;
                end
            end
        end
    endtask

    // Monitor: grant order from the round-robin rule, slave-side mux, and master returns.
    always @(negedge clk) begin
        logic [1:0] eg;
        req_t       f;
        if (mon_en) begin
            if (prev_g == 2'b00)
                eg = (prev_s0 && prev_s1) ? ((last_srv == 1) ? 2'b01 : 2'b10) : {prev_s1, prev_s0};
            else if ((prev_g[0] && (prev_a0 || !prev_s0)) || (prev_g[1] && (prev_a1 || !prev_s1)))
                eg = 2'b00;
            else
                eg = prev_g;
            chk("gnt", 64'(gnt_o), 64'(eg));
            chk("err0", 64'(m0_err_o), 64'd0);
            chk("err1", 64'(m1_err_o), 64'd0);
            if (gnt_o == 2'b00) chk("idle_stb", 64'(s_stb_o), 64'd0);
            if (!gnt_o[0]) chk("m0_quiet", {31'd0, m0_ack_o, m0_dat_o}, 64'd0);
            if (!gnt_o[1]) chk("m1_quiet", {31'd0, m1_ack_o, m1_dat_o}, 64'd0);
            if (s_stb_o) begin
                if (gnt_o[0] && exp0_q.size() > 0) f = exp0_q[0];
                else if (gnt_o[1] && exp1_q.size() > 0) f = exp1_q[0];
                else begin
                    f.adr = ~s_adr_o; f.dat = '0; f.we = 1'b0; f.sel = '0;
                end
                chk("s_adr", 64'(s_adr_o), 64'(f.adr));
                chk("s_wfields", {27'd0, s_we_o, s_sel_o, s_dat_o}, {27'd0, f.we, f.sel, f.dat});
            end
            if (m0_ack_o) begin
                chk("m0_ack_pending", 64'(exp0_q.size() > 0 && m0_stb_i), 64'd1);
                if (exp0_q.size() > 0) begin
                    chk("m0_rdata", 64'(m0_dat_o), 64'(rdata(exp0_q[0].adr)));
                    void'(exp0_q.pop_front());
                end
                last_srv = 0;
                served0++;
            end
            if (m1_ack_o) begin
                chk("m1_ack_pending", 64'(exp1_q.size() > 0 && m1_stb_i), 64'd1);
                if (exp1_q.size() > 0) begin
                    chk("m1_rdata", 64'(m1_dat_o), 64'(rdata(exp1_q[0].adr)));
                    void'(exp1_q.pop_front());
                end
                last_srv = 1;
                served1++;
            end
        end
        ack_seen[0] = m0_ack_o;
        ack_seen[1] = m1_ack_o;
        prev_g  = gnt_o;
        prev_s0 = m0_stb_i;
        prev_s1 = m1_stb_i;
        prev_a0 = m0_ack_o;
        prev_a1 = m1_ack_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        req_t d;
        int   hi, seen_ack;
        logic seen_err;
        logic [31:0] seen_dat;

        // Reset state
        #12;
        chk("rst_stb_gnt", {61'd0, s_stb_o, gnt_o}, 64'd0);
        chk("rst_acks", {60'd0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 64'd0);
        chk("rst_s_adr_dat", {s_adr_o, s_dat_o}, 64'd0);
        chk("rst_m_dat", {m0_dat_o, m1_dat_o}, 64'd0);
        @(posedge clk);
        #1;
        rst_ni   = 1'b1;
        last_srv = 1;
        @(negedge clk);
        mon_en = 1'b1;

        fork
            master_run(0);
            master_run(1);
            begin
                repeat (3000) @(posedge clk);
                stop = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        chk("both_served", 64'(served0 > 10 && served1 > 10), 64'd1);
        chk("queues_drained", 64'(exp0_q.size() + exp1_q.size()), 64'd0);
        mon_en = 1'b0;

        // Unacknowledged transfer: watchdog vs. indefinite wait
        @(posedge clk);
        #1;
        slave_mute = 1'b1;
        d.adr = 32'h8; d.dat = '0; d.we = 1'b0; d.sel = 4'hF;
        set_m(0, d, 1'b1);
        @(posedge clk);
        hi = 0; seen_ack = 0; seen_err = 1'b0; seen_dat = 32'hFFFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m0_ack_o) begin
                seen_ack = 1; seen_err = m0_err_o; seen_dat = m0_dat_o;
                break;
            end
            if (s_stb_o) hi++;
        end
`ifdef ARB_TIMEOUT_EN
        chk("tmo_stb_cycles", 64'(hi), 64'(TMO - 1));
        chk("tmo_ack_err", {62'd0, 1'(seen_ack), seen_err}, 64'd3);
        chk("tmo_dat", 64'(seen_dat), 64'd0);
`else
        chk("hang_stb_cycles", 64'(hi), 64'd40);
        chk("hang_no_ack", 64'(seen_ack), 64'd0);
`endif
        @(posedge clk);
        #1;
        set_m(0, d, 1'b0);
        slave_mute = 1'b0;
        repeat (3) @(posedge clk);

        // Reset while m1 is granted
        #1;
        set_m(1, d, 1'b1);
        @(posedge clk);
        #1;
        chk("pre_rst_gnt1", 64'(gnt_o), 64'd2);
        rst_ni = 1'b0;
        #1;
        chk("async_rst_stb_gnt", {61'd0, s_stb_o, gnt_o}, 64'd0);
        chk("async_rst_no_ack", {62'd0, m0_ack_o, m1_ack_o}, 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        set_m(0, d, 1'b1);
        @(posedge clk);
        #1;
        chk("post_rst_tie_m0", 64'(gnt_o), 64'd1);
        set_m(0, d, 1'b0);
        set_m(1, d, 1'b0);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
